// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trace_pkg
// Brief   : Shared constants, FSM encoding and size helpers for the commit
//           trace transmitter.
// Revision: 1.0
// ============================================================================
package trace_pkg;

    localparam logic [7:0] TRACE_HDR_OK   = 8'hA5;
    localparam logic [7:0] TRACE_HDR_DROP = 8'hA6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } tx_state_e;

    // Stored record: {pending_drop, pc_next, wb, instr, pc}
    function automatic int rec_width(input int xlen);
        return 3 * xlen + 32 + 1;
    endfunction

    function automatic int frame_len(input int xlen);
        return 1 + 3 * xlen / 8 + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module  : trace_fifo
// Brief   : Synchronous FIFO with wrap-bit pointers and an exposed head entry.
// Revision: 1.0
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    always_comb begin
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_count  = wr_ptr_q - rd_ptr_q;
        o_head   = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_trace_tx.sv
`default_nettype none
// ============================================================================
// Module  : commit_trace_tx
// Brief   : Captures retired-instruction records and streams them as framed
//           bytes over a valid/ready link.
// Revision: 1.0
// ============================================================================
module commit_trace_tx
    import trace_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            Clk,
    input  logic            reset_n,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_instr,
    input  logic [XLEN-1:0] commit_wb,
    input  logic [XLEN-1:0] commit_pc_next,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic [7:0]      drop_count,
    output logic            overflow
);

    localparam int REC_W     = rec_width(XLEN);
    localparam int FRAME_LEN = frame_len(XLEN);
    localparam int BODY_LEN  = FRAME_LEN - 1;
    localparam int IDX_W     = $clog2(BODY_LEN);
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_LEN - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic              overflow_q, overflow_d;
    logic              pending_q, pending_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;
    logic              push_ok;
    logic              pop;
    logic [7:0]        body_byte;

    // Body bytes are contiguous LSB-first in the record, so byte k is bits [8k+7:8k].
    assign push_rec = {pending_q, commit_pc_next, commit_wb, commit_instr, commit_pc};
    assign push_ok  = commit_valid && !fifo_full;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (Clk),
        .rst_n       (reset_n),
        .i_push      (push_ok),
        .i_push_data (push_rec),
        .i_pop       (pop),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count),
        .o_head      (head_rec)
    );

    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        pending_d    = pending_q;
        if (commit_valid && fifo_full) begin
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
            overflow_d = 1'b1;
            pending_d  = 1'b1;
        end else if (push_ok) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        body_byte = 8'h00;
        for (int k = 0; k < BODY_LEN; k++) begin
            if (idx_q == IDX_W'(k)) begin
                body_byte = head_rec[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = head_rec[REC_W-1] ? TRACE_HDR_DROP : TRACE_HDR_OK;
                if (tx_ready) begin
                    state_d = BODY;
                    idx_d   = '0;
                end
            end
            BODY: begin
                tx_valid = 1'b1;
                tx_data  = body_byte;
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        pop   = 1'b1;
                        idx_d = '0;
                        // A same-edge push keeps the stream gap-free.
                        state_d = ((fifo_count > CNT_W'(1)) || push_ok) ? HDR : IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            drop_count_q <= 8'h00;
            overflow_q   <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            pending_q    <= pending_d;
        end
    end

    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_commit_trace_tx
// Brief   : Directed, table-driven bench for commit_trace_tx.
// Revision: 1.0
// ============================================================================
module tb_commit_trace_tx;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int FLEN  = 29;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] wb;
        logic [63:0] pc_next;
        int          mode;
        logic [7:0]  hdr;
    } vec_t;

    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic [31:0] commit_instr = '0;
    logic [63:0] commit_wb = '0;
    logic [63:0] commit_pc_next = '0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [7:0]  drop_count;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_f [FLEN];
    vec_t        tbl [3];
    vec_t        q [8];

    commit_trace_tx #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .Clk            (Clk),
        .reset_n        (reset_n),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_instr   (commit_instr),
        .commit_wb      (commit_wb),
        .commit_pc_next (commit_pc_next),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mkrec(input int i);
        vec_t v;
        v.pc      = 64'h0000_0000_8000_0000 + 64'(i) * 64'd4;
        v.instr   = 32'h0013_0513 + 32'(i);
        v.wb      = {32'hDEAD_0000 + 32'(i), 32'h1234_5678};
        v.pc_next = v.pc + 64'd4;
        v.mode    = 0;
        v.hdr     = 8'hA5;
        return v;
    endfunction

    task automatic build_frame(input vec_t v);
        exp_f[0] = v.hdr;
        for (int i = 0; i < 8; i++) exp_f[1 + i]  = v.pc[8*i +: 8];
        for (int i = 0; i < 4; i++) exp_f[9 + i]  = v.instr[8*i +: 8];
        for (int i = 0; i < 8; i++) exp_f[13 + i] = v.wb[8*i +: 8];
        for (int i = 0; i < 8; i++) exp_f[21 + i] = v.pc_next[8*i +: 8];
    endtask

    task automatic drive(input vec_t v, input logic valid);
        commit_valid   = valid;
        commit_pc      = v.pc;
        commit_instr   = v.instr;
        commit_wb      = v.wb;
        commit_pc_next = v.pc_next;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic recv_frame(input int mode, input string nm);
        int         n;
        int         cyc;
        logic       stalled;
        logic [7:0] held;
        n = 0; cyc = 0; stalled = 1'b0; held = 8'h00;
        while (n < FLEN && cyc < 400) begin
            tx_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (stalled) begin
                check($sformatf("%s_hold_valid", nm), {63'd0, tx_valid}, 64'd1);
                check($sformatf("%s_hold_data", nm), {56'd0, tx_data}, {56'd0, held});
            end
            stalled = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    check($sformatf("%s_b%0d", nm, n), {56'd0, tx_data}, {56'd0, exp_f[n]});
                    n++;
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end
            @(posedge Clk); #1;
            cyc++;
        end
        if (n < FLEN) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, expected %0d", nm, n, FLEN);
        end
    endtask

    task automatic push_and_recv(input vec_t v, input string nm);
        drive(v, 1'b1);
        @(posedge Clk); #1;
        commit_valid = 1'b0;
        check({nm, "_lat0_valid"}, {63'd0, tx_valid}, 64'd0);
        @(posedge Clk); #1;
        check({nm, "_lat1_valid"}, {63'd0, tx_valid}, 64'd1);
        check({nm, "_lat1_hdr"}, {56'd0, tx_data}, {56'd0, v.hdr});
        build_frame(v);
        recv_frame(v.mode, nm);
        check({nm, "_end_valid"}, {63'd0, tx_valid}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{pc: 64'h0, instr: 32'h0050_0093, wb: 64'h5, pc_next: 64'h4, mode: 0, hdr: 8'hA5};
        tbl[1] = '{pc: 64'h0000_0000_8000_0000, instr: 32'hFFF0_0113, wb: 64'hFFFF_FFFF_FFFF_FFFF,
                   pc_next: 64'h0000_0000_8000_0004, mode: 1, hdr: 8'hA5};
        tbl[2] = '{pc: 64'h1234_5678_9ABC_DEF0, instr: 32'h0000_006F, wb: 64'h0,
                   pc_next: 64'h0FED_CBA9_8765_4321, mode: 1, hdr: 8'hA5};

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_drop_count", {56'd0, drop_count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        reset_n = 1'b1;
        @(posedge Clk); #1;
        check("idle_after_reset", {63'd0, tx_valid}, 64'd0);
        tx_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            push_and_recv(tbl[i], $sformatf("vec%0d", i));
        end

        // Overflow: six commits into a stalled sink
        tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            q[k] = mkrec(k);
            drive(q[k], 1'b1);
            @(posedge Clk); #1;
        end
        commit_valid = 1'b0;
        check("ovf_drop_count", {56'd0, drop_count}, 64'd2);
        check("ovf_overflow", {63'd0, overflow}, 64'd1);
        check("ovf_stall_valid", {63'd0, tx_valid}, 64'd1);
        check("ovf_stall_hdr", {56'd0, tx_data}, 64'hA5);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                check($sformatf("ovf_b2b%0d_valid", k), {63'd0, tx_valid}, 64'd1);
                check($sformatf("ovf_b2b%0d_hdr", k), {56'd0, tx_data}, 64'hA5);
            end
            build_frame(q[k]);
            recv_frame(0, $sformatf("ovf_rec%0d", k));
        end
        check("ovf_drained", {63'd0, tx_valid}, 64'd0);
        q[6] = mkrec(6);
        q[6].hdr = 8'hA6;
        push_and_recv(q[6], "ovf_rec7");
        q[7] = mkrec(7);
        push_and_recv(q[7], "ovf_rec8");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);

        // Saturation: 4 stored + 300 dropped
        reset_n = 1'b0;
        @(posedge Clk); #1;
        reset_n = 1'b1;
        @(posedge Clk); #1;
        tx_ready = 1'b0;
        drive(mkrec(20), 1'b1);
        repeat (304) @(posedge Clk);
        #1;
        commit_valid = 1'b0;
        check("sat_drop_count", {56'd0, drop_count}, 64'd255);
        check("sat_overflow", {63'd0, overflow}, 64'd1);

        // Reset mid-frame with two records queued
        reset_n = 1'b0;
        @(posedge Clk); #1;
        reset_n = 1'b1;
        @(posedge Clk); #1;
        drive(mkrec(30), 1'b1);
        @(posedge Clk); #1;
        drive(mkrec(31), 1'b1);
        @(posedge Clk); #1;
        commit_valid = 1'b0;
        build_frame(mkrec(30));
        tx_ready = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("mid_byte10", {56'd0, tx_data}, {56'd0, exp_f[10]});
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, tx_valid}, 64'd0);
        check("mid_rst_data", {56'd0, tx_data}, 64'd0);
        check("mid_rst_drop_count", {56'd0, drop_count}, 64'd0);
        check("mid_rst_overflow", {63'd0, overflow}, 64'd0);
        @(posedge Clk); #1;
        reset_n = 1'b1;
        @(posedge Clk); #1;
        check("mid_flushed", {63'd0, tx_valid}, 64'd0);
        push_and_recv(mkrec(32), "mid_restart");

        // Full FIFO: last byte accepted on the same edge as a commit
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(mkrec(40 + k), 1'b1);
            @(posedge Clk); #1;
        end
        commit_valid = 1'b0;
        build_frame(mkrec(40));
        tx_ready = 1'b1;
        repeat (28) @(posedge Clk);
        #1;
        check("ff_last_byte", {56'd0, tx_data}, {56'd0, exp_f[28]});
        drive(mkrec(44), 1'b1);
        @(posedge Clk); #1;
        commit_valid = 1'b0;
        check("ff_drop_count", {56'd0, drop_count}, 64'd1);
        check("ff_overflow", {63'd0, overflow}, 64'd1);
        for (int k = 1; k < 4; k++) begin
            check($sformatf("ff_b2b%0d_valid", k), {63'd0, tx_valid}, 64'd1);
            check($sformatf("ff_b2b%0d_hdr", k), {56'd0, tx_data}, 64'hA5);
            build_frame(mkrec(40 + k));
            recv_frame(0, $sformatf("ff_rec%0d", k));
        end
        check("ff_three_left", {63'd0, tx_valid}, 64'd0);
        q[0] = mkrec(45);
        q[0].hdr = 8'hA6;
        push_and_recv(q[0], "ff_after_drop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
